// File: rtl/cby_param_cfg_pkg.sv
// -----------------------------------------------------------------------------
// cby_param_cfg_pkg
// Shared definitions for the vertical connection block (CBY) configuration
// slice. Holds:
//   - sel_w_f / cfg_bits_f / cnt_w_f : derivation of the select width, the
//     config chain length and the bit-counter width from the block parameters
//   - track_idx_f                    : which track feeds a given mux candidate
//   - ctrl_state_e                   : controller state, decoded from the
//                                      bit counter (EMPTY / LOADING / FULL)
// -----------------------------------------------------------------------------
package cby_param_cfg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2
  } ctrl_state_e;

  // Select width for one ipin mux; never narrower than one bit.
  function automatic int sel_w_f(input int mux_size);
    int w;
    if (mux_size > 1) begin
      w = $clog2(mux_size);
    end else begin
      w = 1;
    end
    return w;
  endfunction

  // Total config chain length: one select field per ipin.
  function automatic int cfg_bits_f(input int num_ipin, input int sel_w);
    return num_ipin * sel_w;
  endfunction

  // Counter must be able to hold the value cfg_bits itself.
  function automatic int cnt_w_f(input int cfg_bits);
    return $clog2(cfg_bits + 1);
  endfunction

  // Track feeding candidate pair j of ipin p. Consecutive pairs step by the
  // stride and wrap around the channel, and each ipin starts one track later.
  function automatic int track_idx_f(input int p, input int j,
                                     input int stride, input int chan_w);
    return (p + j * stride) % chan_w;
  endfunction

endpackage

// File: rtl/cby_ipin_mux.sv
// -----------------------------------------------------------------------------
// cby_ipin_mux
// Select-driven mux for one grid input pin. A select value at or beyond
// MUX_SIZE (unused codes of the select field) drives 0.
// Ports:
//   mux_in  [MUX_SIZE-1:0] candidate track values
//   sel     [SEL_W-1:0]    select field from the active config register
//   mux_out                selected value (combinational)
// -----------------------------------------------------------------------------
module cby_ipin_mux
  import cby_param_cfg_pkg::*;
#(
  parameter int MUX_SIZE = 10,
  parameter int SEL_W    = sel_w_f(MUX_SIZE)
) (
  input  logic [MUX_SIZE-1:0] mux_in,
  input  logic [SEL_W-1:0]    sel,
  output logic                mux_out
);

  logic [MUX_SIZE-1:0] match_s;

  // One-hot decode of the select; out-of-range codes match nothing, so the
  // AND-OR below yields 0 for them without a separate range check.
  always_comb begin
    match_s = {MUX_SIZE{1'b0}};
    for (int i = 0; i < MUX_SIZE; i++) begin
      match_s[i] = (sel == SEL_W'(i));
    end
  end

  // AND-OR reduction of the candidates against the decoded select.
  always_comb begin
    mux_out = |(mux_in & match_s);
  end

endmodule

// File: rtl/cby_param_cfg.sv
// -----------------------------------------------------------------------------
// cby_param_cfg
// Vertical connection block with a serial configuration chain.
// Tracks pass straight through the block; NUM_IPIN grid input pins each pick
// one of MUX_SIZE track candidates according to a select field held in the
// active config register. New configuration is shifted into a shadow register
// and copied to the active register by a commit, which is only accepted once
// exactly CFG_BITS bits have been shifted in since the last commit/reset.
//
// Optional feature (macro CBY_CFG_READBACK_EN): adds the cfg_readback input,
// which reloads the shadow chain from the active register so the live
// configuration can be shifted out on ccff_tail.
//
// Ports:
//   prog_clk, prog_rst_n          clock, asynchronous active-low reset
//   ccff_en, ccff_head            chain shift enable, serial data in
//   ccff_tail                     serial data out (registered)
//   cfg_commit                    shadow -> active copy request (pulse)
//   cfg_readback                  active -> shadow reload (readback build only)
//   cfg_done                      exactly CFG_BITS bits loaded
//   cfg_err                       one-cycle pulse on a rejected commit
//   cfg_valid                     set by the first accepted commit
//   chany_bottom_in/top_in        track inputs
//   chany_bottom_out/top_out      track outputs (feed-through)
//   ipin_out                      grid pin outputs
// -----------------------------------------------------------------------------
module cby_param_cfg
  import cby_param_cfg_pkg::*;
#(
  parameter int CHAN_W       = 11,
  parameter int NUM_IPIN     = 2,
  parameter int MUX_SIZE     = 10,
  parameter int TRACK_STRIDE = 2
) (
  input  logic                prog_clk,
  input  logic                prog_rst_n,
  input  logic                ccff_en,
  input  logic                ccff_head,
  output logic                ccff_tail,
  input  logic                cfg_commit,
`ifdef CBY_CFG_READBACK_EN
  input  logic                cfg_readback,
`endif
  output logic                cfg_done,
  output logic                cfg_err,
  output logic                cfg_valid,
  input  logic [CHAN_W-1:0]   chany_bottom_in,
  input  logic [CHAN_W-1:0]   chany_top_in,
  output logic [CHAN_W-1:0]   chany_bottom_out,
  output logic [CHAN_W-1:0]   chany_top_out,
  output logic [NUM_IPIN-1:0] ipin_out
);

  localparam int SEL_W    = sel_w_f(MUX_SIZE);
  localparam int CFG_BITS = cfg_bits_f(NUM_IPIN, SEL_W);
  localparam int CNT_W    = cnt_w_f(CFG_BITS);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

  logic [CFG_BITS-1:0] shadow_r;
  logic [CFG_BITS-1:0] active_r;
  logic [CNT_W-1:0]    count_r;
  logic                tail_r;
  logic                done_r;
  logic                err_r;
  logic                valid_r;

  logic [CFG_BITS-1:0] shadow_nxt_s;
  logic [CFG_BITS-1:0] active_nxt_s;
  logic [CNT_W-1:0]    count_nxt_s;
  logic                tail_nxt_s;
  logic                err_nxt_s;
  logic                valid_nxt_s;
  logic                commit_ok_s;
  logic                readback_s;
  logic                shift_s;
  ctrl_state_e         state_s;
  logic [NUM_IPIN-1:0] mux_out_s;

  // Readback is suppressed when a commit arrives in the same cycle, so the
  // commit always sees an untouched shadow register.
`ifdef CBY_CFG_READBACK_EN
  assign readback_s = cfg_readback & ~cfg_commit;
`else
  assign readback_s = 1'b0;
`endif

  // Readback takes priority over a shift request.
  assign shift_s = ccff_en & ~readback_s;

  // Tracks are a straight feed-through in both directions.
  assign chany_top_out    = chany_bottom_in;
  assign chany_bottom_out = chany_top_in;

  assign ccff_tail = tail_r;
  assign cfg_done  = done_r;
  assign cfg_err   = err_r;
  assign cfg_valid = valid_r;

  // Controller state decoded from the bit counter.
  always_comb begin
    state_s = ST_EMPTY;
    if (count_r == CNT_ZERO) begin
      state_s = ST_EMPTY;
    end else if (count_r < CNT_FULL) begin
      state_s = ST_LOADING;
    end else begin
      state_s = ST_FULL;
    end
  end

  // Commit acceptance, judged on the pre-edge counter value.
  always_comb begin
    commit_ok_s = 1'b0;
    err_nxt_s   = 1'b0;
    if (cfg_commit) begin
      case (state_s)
        ST_FULL: begin
          commit_ok_s = 1'b1;
        end
        ST_EMPTY, ST_LOADING: begin
          err_nxt_s = 1'b1;
        end
        default: begin
          err_nxt_s = 1'b1;
        end
      endcase
    end else begin
      commit_ok_s = 1'b0;
      err_nxt_s   = 1'b0;
    end
  end

  // Next value of the shadow chain, serial tail, active register and counter.
  always_comb begin
    shadow_nxt_s = shadow_r;
    active_nxt_s = active_r;
    count_nxt_s  = count_r;
    tail_nxt_s   = tail_r;
    valid_nxt_s  = valid_r;

    if (readback_s) begin
      shadow_nxt_s = active_r;
    end else if (shift_s) begin
      shadow_nxt_s    = shadow_r << 1'b1;
      shadow_nxt_s[0] = ccff_head;
      tail_nxt_s      = shadow_r[CFG_BITS-1];
    end else begin
      shadow_nxt_s = shadow_r;
    end

    if (commit_ok_s) begin
      active_nxt_s = shadow_r;
      valid_nxt_s  = 1'b1;
    end else begin
      active_nxt_s = active_r;
    end

    // A shift in the same cycle as an accepted commit is the first bit of
    // the next load, hence count restarts at 1 rather than 0.
    if (readback_s) begin
      count_nxt_s = CNT_ZERO;
    end else if (commit_ok_s) begin
      if (shift_s) begin
        count_nxt_s = CNT_ONE;
      end else begin
        count_nxt_s = CNT_ZERO;
      end
    end else if (shift_s && (state_s != ST_FULL)) begin
      count_nxt_s = count_r + CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Configuration and status state registers.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      shadow_r <= {CFG_BITS{1'b0}};
      active_r <= {CFG_BITS{1'b0}};
      count_r  <= CNT_ZERO;
      tail_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      shadow_r <= shadow_nxt_s;
      active_r <= active_nxt_s;
      count_r  <= count_nxt_s;
      tail_r   <= tail_nxt_s;
      done_r   <= (count_nxt_s == CNT_FULL);
      err_r    <= err_nxt_s;
      valid_r  <= valid_nxt_s;
    end
  end

  // One mux per ipin; candidate 2j is the bottom track and 2j+1 the top
  // track at the same channel position.
  for (genvar p = 0; p < NUM_IPIN; p++) begin : g_ipin
    logic [MUX_SIZE-1:0] mux_in_s;

    for (genvar j = 0; j < MUX_SIZE / 2; j++) begin : g_cand
      localparam int TRK = track_idx_f(p, j, TRACK_STRIDE, CHAN_W);
      assign mux_in_s[2*j]   = chany_bottom_in[TRK];
      assign mux_in_s[2*j+1] = chany_top_in[TRK];
    end

    cby_ipin_mux #(
      .MUX_SIZE (MUX_SIZE),
      .SEL_W    (SEL_W)
    ) u_mux (
      .mux_in  (mux_in_s),
      .sel     (active_r[p*SEL_W +: SEL_W]),
      .mux_out (mux_out_s[p])
    );
  end

  // Pins stay at 0 until a configuration has been committed.
  always_comb begin
    if (valid_r) begin
      ipin_out = mux_out_s;
    end else begin
      ipin_out = {NUM_IPIN{1'b0}};
    end
  end

endmodule

// File: tb/tb_cby_param_cfg.sv
// -----------------------------------------------------------------------------
// tb_cby_param_cfg
// Self-checking bench for cby_param_cfg at default parameters (SEL_W=4,
// CFG_BITS=8). The reference model keeps the chain, active word, bit count
// and flags as plain integers and computes each pin from the track formula.
// Define CBY_CFG_READBACK_EN to also exercise the readback port.
// -----------------------------------------------------------------------------
module tb_cby_param_cfg;

  localparam int CHAN_W       = 11;
  localparam int NUM_IPIN     = 2;
  localparam int MUX_SIZE     = 10;
  localparam int TRACK_STRIDE = 2;
  localparam int SEL_W        = 4;
  localparam int CFG_BITS     = 8;

  logic                prog_clk   = 1'b0;
  logic                prog_rst_n = 1'b0;
  logic                ccff_en    = 1'b0;
  logic                ccff_head  = 1'b0;
  logic                cfg_commit = 1'b0;
`ifdef CBY_CFG_READBACK_EN
  logic                cfg_readback = 1'b0;
`endif
  logic                ccff_tail;
  logic                cfg_done;
  logic                cfg_err;
  logic                cfg_valid;
  logic [CHAN_W-1:0]   bot = '0;
  logic [CHAN_W-1:0]   top = '0;
  logic [CHAN_W-1:0]   bot_out;
  logic [CHAN_W-1:0]   top_out;
  logic [NUM_IPIN-1:0] ipin_out;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_shadow, m_active, m_count;
  bit m_valid, m_tail, m_err;

  cby_param_cfg #(
    .CHAN_W(CHAN_W), .NUM_IPIN(NUM_IPIN), .MUX_SIZE(MUX_SIZE), .TRACK_STRIDE(TRACK_STRIDE)
  ) dut (
    .prog_clk         (prog_clk),
    .prog_rst_n       (prog_rst_n),
    .ccff_en          (ccff_en),
    .ccff_head        (ccff_head),
    .ccff_tail        (ccff_tail),
    .cfg_commit       (cfg_commit),
`ifdef CBY_CFG_READBACK_EN
    .cfg_readback     (cfg_readback),
`endif
    .cfg_done         (cfg_done),
    .cfg_err          (cfg_err),
    .cfg_valid        (cfg_valid),
    .chany_bottom_in  (bot),
    .chany_top_in     (top),
    .chany_bottom_out (bot_out),
    .chany_top_out    (top_out),
    .ipin_out         (ipin_out)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic model_reset();
    m_shadow = 0; m_active = 0; m_count = 0;
    m_valid = 0; m_tail = 0; m_err = 0;
  endtask

  // Expected value of pin p from the track formula.
  function automatic bit ref_ipin(input int p);
    int sel, t;
    sel = (m_active >> (p * SEL_W)) & ((1 << SEL_W) - 1);
    if (!m_valid || sel >= MUX_SIZE) return 1'b0;
    t = (p + (sel / 2) * TRACK_STRIDE) % CHAN_W;
    return (sel % 2 == 1) ? top[t] : bot[t];
  endfunction

  function automatic logic [NUM_IPIN-1:0] ref_pins();
    logic [NUM_IPIN-1:0] v;
    for (int p = 0; p < NUM_IPIN; p++) v[p] = ref_ipin(p);
    return v;
  endfunction

  // Drive one clock cycle of inputs and advance the model.
  task automatic cyc(input bit en, input bit head, input bit commit, input bit rb);
    bit full, rb_eff;
    ccff_en = en; ccff_head = head; cfg_commit = commit;
`ifdef CBY_CFG_READBACK_EN
    cfg_readback = rb;
    rb_eff = rb && !commit;
`else
    rb_eff = 1'b0;
`endif
    @(posedge prog_clk);
    #1;
    full  = (m_count == CFG_BITS);
    m_err = commit && !full;
    if (commit && full) begin
      m_active = m_shadow;
      m_valid  = 1'b1;
    end
    if (rb_eff) begin
      m_shadow = m_active;
      m_count  = 0;
    end else begin
      if (en) begin
        m_tail   = (m_shadow >> (CFG_BITS - 1)) & 1;
        m_shadow = ((m_shadow << 1) | int'(head)) & ((1 << CFG_BITS) - 1);
      end
      if (commit && full) m_count = en ? 1 : 0;
      else if (en && m_count < CFG_BITS) m_count = m_count + 1;
    end
    ccff_en = 1'b0; ccff_head = 1'b0; cfg_commit = 1'b0;
`ifdef CBY_CFG_READBACK_EN
    cfg_readback = 1'b0;
`endif
  endtask

  task automatic apply_reset();
    prog_rst_n = 1'b0;
    repeat (2) @(posedge prog_clk);
    #1;
    prog_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    bot = '1; top = '1;
    prog_rst_n = 1'b0;
    #1;
    checks++; if (ipin_out !== 2'b00) begin $display("FAIL reset_ipin got=%b exp=00", ipin_out); failures++; end
    checks++; if (cfg_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", cfg_valid); failures++; end
    checks++; if (cfg_done !== 1'b0 || cfg_err !== 1'b0 || ccff_tail !== 1'b0) begin
      $display("FAIL reset_flags got done=%b err=%b tail=%b exp=0", cfg_done, cfg_err, ccff_tail); failures++; end
    checks++; if (top_out !== 11'h7FF || bot_out !== 11'h7FF) begin
      $display("FAIL reset_feedthru got top=%h bot=%h exp=7ff", top_out, bot_out); failures++; end
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      bot = CHAN_W'($urandom); top = CHAN_W'($urandom);
      #1;
      checks++; if (top_out !== bot || bot_out !== top) begin
        $display("FAIL feedthru got top=%h bot=%h exp=%h %h", top_out, bot_out, bot, top); failures++; end
      checks++; if (ipin_out !== 2'b00) begin $display("FAIL unconfigured_ipin got=%b exp=00", ipin_out); failures++; end
    end
  endtask

  task automatic test_directed_load();
    logic [7:0] seq;
    seq = 8'b0011_0010;
    for (int k = 7; k >= 0; k--) cyc(1'b1, seq[k], 1'b0, 1'b0);
    checks++; if (cfg_done !== 1'b1) begin $display("FAIL load_done got=%b exp=1", cfg_done); failures++; end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (cfg_valid !== 1'b1 || cfg_err !== 1'b0) begin
      $display("FAIL commit_accept got valid=%b err=%b exp=1 0", cfg_valid, cfg_err); failures++; end
    checks++; if (cfg_done !== 1'b0) begin $display("FAIL done_after_commit got=%b exp=0", cfg_done); failures++; end
    for (int k = 0; k < 6; k++) begin
      bot = CHAN_W'($urandom); top = CHAN_W'($urandom);
      #1;
      checks++; if (ipin_out[0] !== bot[2] || ipin_out[1] !== top[3]) begin
        $display("FAIL sel32_route got=%b exp=%b%b", ipin_out, top[3], bot[2]); failures++; end
    end
  endtask

  task automatic test_reject();
    apply_reset();
    bot = '1; top = '1;
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (cfg_err !== 1'b1) begin $display("FAIL reject_err got=%b exp=1", cfg_err); failures++; end
    checks++; if (cfg_valid !== 1'b0 || ipin_out !== 2'b00) begin
      $display("FAIL reject_state got valid=%b ipin=%b exp=0 00", cfg_valid, ipin_out); failures++; end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (cfg_err !== 1'b0) begin $display("FAIL reject_err_pulse got=%b exp=0", cfg_err); failures++; end
  endtask

  task automatic test_oob_sel();
    apply_reset();
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (cfg_valid !== 1'b1) begin $display("FAIL oob_valid got=%b exp=1", cfg_valid); failures++; end
    for (int k = 0; k < 4; k++) begin
      bot = CHAN_W'($urandom); top = CHAN_W'($urandom);
      #1;
      checks++; if (ipin_out !== 2'b00) begin $display("FAIL oob_ipin got=%b exp=00", ipin_out); failures++; end
    end
  endtask

  task automatic test_commit_and_shift();
    apply_reset();
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 1'($urandom), 1'b1, 1'b0);
    checks++; if (cfg_valid !== 1'b1 || cfg_err !== 1'b0 || cfg_done !== 1'b0) begin
      $display("FAIL commit_shift got valid=%b err=%b done=%b exp=1 0 0", cfg_valid, cfg_err, cfg_done); failures++; end
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
      checks++; if (cfg_done !== (k == 6)) begin
        $display("FAIL count_after_commit_shift step=%0d got=%b exp=%b", k, cfg_done, (k == 6)); failures++; end
    end
    checks++; if (ipin_out !== ref_pins()) begin
      $display("FAIL commit_shift_ipin got=%b exp=%b", ipin_out, ref_pins()); failures++; end
  endtask

  task automatic test_reset_mid_shift();
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
    #2;
    prog_rst_n = 1'b0;
    #1;
    checks++; if (cfg_valid !== 1'b0 || ipin_out !== 2'b00 || cfg_done !== 1'b0 || ccff_tail !== 1'b0) begin
      $display("FAIL async_reset got valid=%b ipin=%b done=%b tail=%b exp=0", cfg_valid, ipin_out, cfg_done, ccff_tail);
      failures++; end
    @(posedge prog_clk);
    #1;
    prog_rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (cfg_err !== 1'b1 || cfg_valid !== 1'b0) begin
      $display("FAIL partial_after_reset got err=%b valid=%b exp=1 0", cfg_err, cfg_valid); failures++; end
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (cfg_err !== 1'b0 || cfg_valid !== 1'b1) begin
      $display("FAIL full_after_reset got err=%b valid=%b exp=0 1", cfg_err, cfg_valid); failures++; end
  endtask

  task automatic test_random();
    bit en, hd, cm, rb;
    logic [NUM_IPIN-1:0] exp_pins;
    for (int n = 0; n < 300; n++) begin
      en = ($urandom_range(0, 9) < 7);
      hd = 1'($urandom);
      cm = ($urandom_range(0, 19) < 3);
      rb = ($urandom_range(0, 19) < 2);
      bot = CHAN_W'($urandom); top = CHAN_W'($urandom);
      cyc(en, hd, cm, rb);
      exp_pins = ref_pins();
      checks++; if (ipin_out !== exp_pins) begin
        $display("FAIL rand_ipin n=%0d got=%b exp=%b", n, ipin_out, exp_pins); failures++; end
      checks++; if (cfg_done !== (m_count == CFG_BITS)) begin
        $display("FAIL rand_done n=%0d got=%b exp=%b", n, cfg_done, (m_count == CFG_BITS)); failures++; end
      checks++; if (cfg_err !== m_err || cfg_valid !== m_valid) begin
        $display("FAIL rand_flags n=%0d got err=%b valid=%b exp=%b %b", n, cfg_err, cfg_valid, m_err, m_valid);
        failures++; end
      checks++; if (ccff_tail !== m_tail) begin
        $display("FAIL rand_tail n=%0d got=%b exp=%b", n, ccff_tail, m_tail); failures++; end
    end
  endtask

`ifdef CBY_CFG_READBACK_EN
  task automatic test_readback();
    logic [7:0] word;
    word = 8'h32;
    apply_reset();
    for (int k = 7; k >= 0; k--) cyc(1'b1, word[k], 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (cfg_done !== 1'b0) begin $display("FAIL readback_count got done=%b exp=0", cfg_done); failures++; end
    for (int k = 7; k >= 0; k--) begin
      cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
      checks++; if (ccff_tail !== word[k]) begin
        $display("FAIL readback_bit%0d got=%b exp=%b", k, ccff_tail, word[k]); failures++; end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_directed_load();
    test_reject();
    test_oob_sel();
    test_commit_and_shift();
    test_reset_mid_shift();
    test_random();
`ifdef CBY_CFG_READBACK_EN
    test_readback();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
